// File: rtl/pc_gen_if.sv
// pc_gen_if: control inputs and PC/status outputs of the PC-generation stage
interface pc_gen_if #(
    parameter int CNT_W = 32
);
    logic             i_stall;
    logic             i_br_taken;
    logic             i_jalr;
    logic [31:0]      i_target;
    logic             i_halt;
    logic             i_resume;
    logic [31:0]      o_pc;
    logic [31:0]      o_pc_plus4;
    logic             o_halted;
    logic             o_misalign;
    logic [CNT_W-1:0] o_retired;

    modport master (
        output i_stall, i_br_taken, i_jalr, i_target, i_halt, i_resume,
        input  o_pc, o_pc_plus4, o_halted, o_misalign, o_retired
    );

    modport slave (
        input  i_stall, i_br_taken, i_jalr, i_target, i_halt, i_resume,
        output o_pc, o_pc_plus4, o_halted, o_misalign, o_retired
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program counter with branch/JALR redirect, stall, debug halt/resume and retire counter
// Define PC_MISALIGN_TRAP_EN to trap on redirects whose target bit 1 is set; otherwise such
// targets are word-aligned and the redirect retires normally.
module pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 32
) (
    input logic     i_clk,
    input logic     i_reset,
    pc_gen_if.slave bus
);
    typedef enum logic [1:0] {RUN, HALT, TRAP} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d, pc_plus4, target;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             redirect, misalign;

    assign pc_plus4       = pc_q + 32'd4;
    assign redirect       = bus.i_jalr | bus.i_br_taken;
    assign target         = bus.i_jalr ? {bus.i_target[31:1], 1'b0} :
                            bus.i_br_taken ? bus.i_target : pc_plus4;
    assign misalign       = redirect & target[1];

    assign bus.o_pc       = pc_q;
    assign bus.o_pc_plus4 = pc_plus4;
    assign bus.o_retired  = cnt_q;
    assign bus.o_halted   = state_q != RUN;
`ifdef PC_MISALIGN_TRAP_EN
    assign bus.o_misalign = state_q == TRAP;
`else
    assign bus.o_misalign = 1'b0;
`endif

    // architectural state: PC, retire count and run/halt/trap mode
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // next mode, next PC and retire decision; halt outranks stall, stall outranks redirect
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (bus.i_halt) begin
                    state_d = HALT;
                end else if (!bus.i_stall) begin
                    if (misalign) begin
`ifdef PC_MISALIGN_TRAP_EN
                        state_d = TRAP;
`else
                        pc_d  = {target[31:2], 2'b00};
                        cnt_d = cnt_q + CNT_W'(1);
`endif
                    end else begin
                        pc_d  = target;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HALT: state_d = (bus.i_resume && !bus.i_halt) ? RUN : HALT;
            TRAP: begin
                if (bus.i_resume) begin
                    state_d = RUN;
                    pc_d    = pc_plus4;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generation stage of the single-cycle RISC-V core. Holds the architectural PC, selects the next PC from sequential, branch/JAL and JALR sources, supports pipeline-style stall and debug halt/resume, and counts retired instructions. Its `o_pc` drives instruction-memory fetch and is the `i_pc` input of `pc_debug` directly downstream.

## Interface

Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `i_clk`, in, 1: core clock; all state updates on the rising edge.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_stall`, in, 1: hold PC this cycle.
- `i_br_taken`, in, 1: branch taken or JAL; redirect to `i_target`.
- `i_jalr`, in, 1: JALR; redirect to `{i_target[31:1],1'b0}`.
- `i_target`, in, 32: redirect target from the ALU.
- `i_halt`, in, 1: debug halt request.
- `i_resume`, in, 1: debug resume request; also clears a trap.
- `o_pc`, out, 32: current PC, registered.
- `o_pc_plus4`, out, 32: `o_pc + 4`, combinational, wraps modulo 2^32.
- `o_halted`, out, 1: high in HALT or TRAP.
- `o_misalign`, out, 1: high in TRAP.
- `o_retired`, out, CNT_W: count of retired instructions, registered.

## Operation

FSM states: RUN, HALT, TRAP.

Redirect target:
- `i_jalr`=1: `{i_target[31:1],1'b0}`. `i_jalr` has priority over `i_br_taken`.
- Otherwise, `i_br_taken`=1: `i_target`.
- Otherwise: `o_pc_plus4`.

RUN, evaluated in priority order:
- `i_halt`=1: PC holds, no retire, next state HALT. Halt has priority over stall and redirect.
- `i_stall`=1: PC holds, no retire, stay in RUN.
- Misaligned redirect (redirect active and target bit 1 = 1): handling depends on Configuration.
- Otherwise: PC ← selected target, `o_retired` += 1, stay in RUN.

HALT:
- PC and counter hold.
- `i_resume`=1 and `i_halt`=0: next state RUN, PC unchanged.
- `i_resume`=1 and `i_halt`=1 together: stay in HALT.

TRAP:
- PC holds at the faulting instruction; counter holds.
- `i_resume`=1: PC ← `o_pc_plus4`, `o_retired` += 1, next state RUN.
- `i_halt` is ignored in TRAP.

Counter:
- Wraps from 2^CNT_W−1 to 0 with no flag.

Reset:
- `o_pc` = RESET_VECTOR, `o_retired` = 0, state = RUN, `o_halted` = 0, `o_misalign` = 0.

## Timing

- `o_pc`, `o_retired`, state, `o_halted`, `o_misalign` are all registered and change only on the rising edge of `i_clk`.
- `o_pc_plus4` follows `o_pc` combinationally, with zero latency.
- Redirect latency: a target presented in cycle N appears on `o_pc` after edge N (one cycle).
- `i_reset` low forces reset values immediately, with no clock needed. Reset mid-halt or mid-trap returns to RUN at RESET_VECTOR.
- Reset deassertion is synchronized externally. The first update occurs on the first rising edge with `i_reset` high.
- All inputs are sampled only at the rising edge. No input is registered internally.

## Configuration

`PC_MISALIGN_TRAP_EN`

- Defined:
  - A misaligned redirect in RUN does not update the PC and does not retire.
  - The FSM enters TRAP, so `o_misalign`=1 and `o_halted`=1 from the next edge.
- Undefined:
  - Target bits [1:0] are forced to 2'b00, and the redirect completes and retires normally.
  - TRAP is unreachable, and `o_misalign` is tied to 0.

## Test plan

1. Reset, then 3 free-running cycles with RESET_VECTOR=0 → `o_pc` = 0, 4, 8, C; `o_retired` = 0, 1, 2, 3; `o_pc_plus4` = `o_pc`+4 every cycle.
2. At PC=8, `i_br_taken`=1, `i_target`=0x100 → PC=0x100 next. Then `i_jalr`=1, `i_target`=0x205 → PC=0x204. Then `i_jalr`=1 and `i_br_taken`=1 with `i_target`=0x301 → PC=0x300 (JALR wins).
3. `i_stall`=1 for 2 cycles at PC=0x10 → PC and `o_retired` hold. Next PC is 0x14. Stall together with `i_br_taken` → no redirect.
4. `i_halt` at PC=0x20 → `o_halted`=1, PC frozen for 5 cycles. `i_halt`+`i_resume` together → stays halted. `i_resume` alone → PC=0x24 one cycle after the RUN edge.
5. Branch to 0x102:
   - With `PC_MISALIGN_TRAP_EN` defined: PC holds at the faulting PC, `o_misalign`=1. `i_resume` → PC = faulting PC+4, `o_misalign`=0.
   - With the macro undefined: PC=0x100 and `o_misalign` stays 0.
6. Assert `i_reset` low mid-cycle while in HALT → outputs return to reset values before the next edge. With CNT_W=4, 16 sequential retires → `o_retired` wraps to 0.
